// File: rtl/agex_if.sv
// Decode-side and MEM-side handshake bundle for the execute/address stage.
interface agex_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned REGBITS = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [3:0]         in_op;
   logic [XLEN-1:0]    in_pc;
   logic [XLEN-1:0]    in_rs1;
   logic [XLEN-1:0]    in_rs2;
   logic [XLEN-1:0]    in_imm;
   logic [REGBITS-1:0] in_rd;

   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    out_result;
   logic [REGBITS-1:0] out_rd;
   logic [XLEN-1:0]    out_pc;
   logic               out_redirect;
   logic [XLEN-1:0]    out_target;

   // Decode/MEM side: offers ops, consumes result bundles.
   modport master (
      output in_valid, in_op, in_pc, in_rs1, in_rs2, in_imm, in_rd, out_ready,
      input  in_ready, out_valid, out_result, out_rd, out_pc, out_redirect, out_target
   );

   // Execute unit side.
   modport slave (
      input  in_valid, in_op, in_pc, in_rs1, in_rs2, in_imm, in_rd, out_ready,
      output in_ready, out_valid, out_result, out_rd, out_pc, out_redirect, out_target
   );
endinterface

// File: rtl/agex_exec_unit.sv
// Execute/address stage: single-cycle ALU/branch/jump, fixed-latency MUL,
// iterative restoring DIVU/REMU, valid/ready on both sides, flush squashes.
module agex_exec_unit #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned REGBITS = 5,
   parameter int unsigned MUL_LAT = 3
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  flush,
   agex_if.slave bus
);
   localparam int unsigned LMAX  = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
   localparam int unsigned CNT_W = $clog2(LMAX + 1);

   localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLT  = 4'd5,  OP_SLTU = 4'd6,  OP_BEQ  = 4'd7;
   localparam logic [3:0] OP_BNE  = 4'd8,  OP_BLT  = 4'd9,  OP_BGEU = 4'd10, OP_JAL  = 4'd11;
   localparam logic [3:0] OP_JALR = 4'd12, OP_MUL  = 4'd13, OP_DIVU = 4'd14, OP_REMU = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         op_q, op_d;
   logic [XLEN-1:0]    rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [XLEN-1:0]    result_q, result_d, pc_q, pc_d, target_q, target_d;
   logic [REGBITS-1:0] rd_q, rd_d;
   logic               redirect_q, redirect_d;

   logic               accept;
   logic               taken;
   logic [XLEN-1:0]    step_rem, step_quo, first_rem, first_quo;

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                  input logic [XLEN-1:0] quo,
                                                  input logic [XLEN-1:0] dvs);
      logic [XLEN:0]   sh;
      logic [XLEN-1:0] diff;
      sh   = {rem, quo[XLEN-1]};
      diff = sh[XLEN-1:0] - dvs;
      if (sh >= {1'b0, dvs}) return {diff, quo[XLEN-2:0], 1'b1};
      else                   return {sh[XLEN-1:0], quo[XLEN-2:0], 1'b0};
   endfunction

   // Divider steps: ongoing iteration and the first iteration done at accept.
   assign {step_rem, step_quo}   = div_step(rem_q, quo_q, dvs_q);
   assign {first_rem, first_quo} = div_step('0, bus.in_rs1, bus.in_rs2);

   assign bus.in_ready     = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
   assign accept           = bus.in_valid && bus.in_ready;
   assign bus.out_valid    = (state_q == S_DONE);
   assign bus.out_result   = result_q;
   assign bus.out_rd       = rd_q;
   assign bus.out_pc       = pc_q;
   assign bus.out_redirect = redirect_q;
   assign bus.out_target   = target_q;

   // Branch condition for the offered op.
   always_comb begin
      taken = 1'b0;
      case (bus.in_op)
         OP_BEQ:  taken = (bus.in_rs1 == bus.in_rs2);
         OP_BNE:  taken = (bus.in_rs1 != bus.in_rs2);
         OP_BLT:  taken = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
         OP_BGEU: taken = (bus.in_rs1 >= bus.in_rs2);
         default: taken = 1'b0;
      endcase
   end

   // Next state, iteration and result bundle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      result_d   = result_q;
      pc_d       = pc_q;
      rd_d       = rd_q;
      redirect_d = redirect_q;
      target_d   = target_q;

      case (state_q)
         S_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if ((op_q == OP_DIVU) || (op_q == OP_REMU)) begin
               rem_d = step_rem;
               quo_d = step_quo;
            end
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
               if (op_q == OP_DIVU) result_d = step_quo;
               if (op_q == OP_REMU) result_d = step_rem;
            end
         end
         S_DONE: if (bus.out_ready) state_d = S_IDLE;
         default: ;
      endcase

      if (accept) begin
         state_d    = S_DONE;
         op_d       = bus.in_op;
         pc_d       = bus.in_pc;
         rd_d       = bus.in_rd;
         redirect_d = 1'b0;
         target_d   = '0;
         result_d   = '0;
         case (bus.in_op)
            OP_ADD:  result_d = bus.in_rs1 + bus.in_rs2;
            OP_SUB:  result_d = bus.in_rs1 - bus.in_rs2;
            OP_AND:  result_d = bus.in_rs1 & bus.in_rs2;
            OP_OR:   result_d = bus.in_rs1 | bus.in_rs2;
            OP_XOR:  result_d = bus.in_rs1 ^ bus.in_rs2;
            OP_SLT:  result_d = {{(XLEN-1){1'b0}}, ($signed(bus.in_rs1) < $signed(bus.in_rs2))};
            OP_SLTU: result_d = {{(XLEN-1){1'b0}}, (bus.in_rs1 < bus.in_rs2)};
            OP_BEQ, OP_BNE, OP_BLT, OP_BGEU: begin
               redirect_d = taken;
               target_d   = taken ? (bus.in_pc + bus.in_imm) : '0;
            end
            OP_JAL: begin
               result_d   = bus.in_pc + XLEN'(4);
               redirect_d = 1'b1;
               target_d   = bus.in_pc + bus.in_imm;
            end
            OP_JALR: begin
               result_d   = bus.in_pc + XLEN'(4);
               redirect_d = 1'b1;
               target_d   = (bus.in_rs1 + bus.in_imm) & ~XLEN'(1);
            end
            OP_MUL: begin
               result_d = bus.in_rs1 * bus.in_rs2;
               if (MUL_LAT > 1) begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_W'(MUL_LAT - 1);
               end
            end
            OP_DIVU, OP_REMU: begin
               if (bus.in_rs2 == '0) begin
                  result_d = (bus.in_op == OP_DIVU) ? '1 : bus.in_rs1;
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_W'(XLEN - 1);
                  rem_d   = first_rem;
                  quo_d   = first_quo;
                  dvs_d   = bus.in_rs2;
               end
            end
            default: ;
         endcase
      end

      // Flush abandons whatever is in flight or held.
      if (flush) state_d = S_IDLE;
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         result_q   <= '0;
         pc_q       <= '0;
         rd_q       <= '0;
         redirect_q <= 1'b0;
         target_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         result_q   <= result_d;
         pc_q       <= pc_d;
         rd_q       <= rd_d;
         redirect_q <= redirect_d;
         target_q   <= target_d;
      end
   end
endmodule
